// File: rtl/cell_fetch_arbiter_if.sv
// Request, memory and response signals of the cell fetch arbiter.
// The arbiter connects through the master modport, and the requesters, memory and consumer use slave.
interface cell_fetch_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_ptr;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_ptr;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_id;
    logic [DATA_WIDTH-1:0] resp_tag;
    logic [DATA_WIDTH-1:0] resp_f1;
    logic [DATA_WIDTH-1:0] resp_f2;
    logic [DATA_WIDTH-1:0] resp_f3;
    logic                  resp_err;

    modport master (
        input  req0_valid, req0_ptr, req1_valid, req1_ptr, mem_data, resp_ready,
        output req0_ready, req1_ready, mem_addr,
               resp_valid, resp_id, resp_tag, resp_f1, resp_f2, resp_f3, resp_err
    );

    modport slave (
        output req0_valid, req0_ptr, req1_valid, req1_ptr, mem_data, resp_ready,
        input  req0_ready, req1_ready, mem_addr,
               resp_valid, resp_id, resp_tag, resp_f1, resp_f2, resp_f3, resp_err
    );
endinterface

// File: rtl/cell_fetch_arbiter.sv
// Round-robin two-port arbiter that fetches a tagged object (tag + up to 3 fields)
// from a one-cycle-latency memory and presents it as a single response beat.
module cell_fetch_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    cell_fetch_arbiter_if.master bus
);
    localparam logic [DATA_WIDTH-1:0] TAG_NIL       = DATA_WIDTH'(8'h00);
    localparam logic [DATA_WIDTH-1:0] TAG_NUMBER    = DATA_WIDTH'(8'h01);
    localparam logic [DATA_WIDTH-1:0] TAG_CONS      = DATA_WIDTH'(8'h02);
    localparam logic [DATA_WIDTH-1:0] TAG_FUNC_PRIM = DATA_WIDTH'(8'h03);

    typedef enum logic [1:0] {S_IDLE, S_TAG, S_FIELD, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  id_q, id_d;
    logic                  last_q, last_d;
    logic [2:0]            idx_q, idx_d;
    logic [2:0]            len_q, len_d;
    logic [DATA_WIDTH-1:0] tag_q, tag_d;
    logic [DATA_WIDTH-1:0] f1_q, f1_d;
    logic [DATA_WIDTH-1:0] f2_q, f2_d;
    logic [DATA_WIDTH-1:0] f3_q, f3_d;
    logic                  err_q, err_d;

    logic                  ready0_c, ready1_c, pick_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [2:0]            tag_len_c;
    logic                  tag_err_c;

    always_comb begin
        tag_len_c = 3'd1;
        tag_err_c = 1'b0;
        case (bus.mem_data)
            TAG_NIL:       tag_len_c = 3'd1;
            TAG_NUMBER:    tag_len_c = 3'd2;
            TAG_CONS:      tag_len_c = 3'd3;
            TAG_FUNC_PRIM: tag_len_c = 3'd4;
            default:       tag_err_c = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        last_d     = last_q;
        idx_d      = idx_q;
        len_d      = len_q;
        tag_d      = tag_q;
        f1_d       = f1_q;
        f2_d       = f2_q;
        f3_d       = f3_q;
        err_d      = err_q;
        ready0_c   = 1'b0;
        ready1_c   = 1'b0;
        mem_addr_c = '0;
        // Tie goes to whoever did not win last; a lone requester always wins.
        pick_c     = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;

        case (state_q)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    ready0_c   = ~pick_c;
                    ready1_c   = pick_c;
                    ptr_d      = pick_c ? bus.req1_ptr : bus.req0_ptr;
                    mem_addr_c = ptr_d;
                    id_d       = pick_c;
                    last_d     = pick_c;
                    f1_d       = '0;
                    f2_d       = '0;
                    f3_d       = '0;
                    state_d    = S_TAG;
                end
            end
            S_TAG: begin
                tag_d = bus.mem_data;
                err_d = tag_err_c;
                len_d = tag_len_c;
                if (tag_len_c > 3'd1) begin
                    mem_addr_c = ptr_q + ADDR_WIDTH'(1);
                    idx_d      = 3'd1;
                    state_d    = S_FIELD;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_FIELD: begin
                case (idx_q)
                    3'd1:    f1_d = bus.mem_data;
                    3'd2:    f2_d = bus.mem_data;
                    3'd3:    f3_d = bus.mem_data;
                    default: ;
                endcase
                if (idx_q < len_q - 3'd1) begin
                    mem_addr_c = ptr_q + ADDR_WIDTH'(idx_q + 3'd1);
                    idx_d      = idx_q + 3'd1;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            idx_q   <= '0;
            len_q   <= '0;
            tag_q   <= '0;
            f1_q    <= '0;
            f2_q    <= '0;
            f3_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            tag_q   <= tag_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            f3_q    <= f3_d;
            err_q   <= err_d;
        end
    end

    // Grant and address are combinational from IDLE, so reset must mask them directly.
    assign bus.req0_ready = rst_n & ready0_c;
    assign bus.req1_ready = rst_n & ready1_c;
    assign bus.mem_addr   = rst_n ? mem_addr_c : '0;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_id    = id_q;
    assign bus.resp_tag   = tag_q;
    assign bus.resp_f1    = f1_q;
    assign bus.resp_f2    = f2_q;
    assign bus.resp_f3    = f3_q;
    assign bus.resp_err   = err_q;
endmodule

// File: doc/cell_fetch_arbiter.md
# cell_fetch_arbiter

Sequencer and two-port arbiter in front of the registered-read object memory (ROM or RAM, one-cycle read latency). It accepts a cell pointer from either of two requesters (evaluator and printer/GC walker), reads the tag word, decodes the object length from the tag, and reads the remaining fields. It then returns the whole object as one response beat. Only this block drives the memory address bus.

## Interface
- ADDR_WIDTH, 8, memory address and pointer width
- DATA_WIDTH, 8, memory word width; tags and fields are one word each
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester fetch request
- req0_ptr / req1_ptr  in  ADDR_WIDTH  cell address (tag word)
- req0_ready / req1_ready  out  1  request accepted this cycle (grant pulse)
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_data  in  DATA_WIDTH  memory read data, valid one cycle after mem_addr
- resp_valid  out  1  object response valid
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester that owns the response
- resp_tag  out  DATA_WIDTH  tag word
- resp_f1 / resp_f2 / resp_f3  out  DATA_WIDTH  field words 1..3; unused fields are 0
- resp_err  out  1  unknown tag

## Operation
- Object length n by tag. lisp::NIL is 1 word. TYPE_NUMBER is 2 words (value). TYPE_CONS is 3 words (car, cdr). TYPE_FUNC_PRIM is 4 words (prim id, 2 reserved). Any other tag is n=1 with resp_err=1.
- States:
  - IDLE. If any req_valid, arbitrate, pulse the winner's ready, latch ptr and id, drive mem_addr=ptr, and go to TAG. Otherwise mem_addr=0.
  - TAG. Capture mem_data as the tag and compute n. If n>1, drive mem_addr=ptr+1, set idx=1, and go to FIELD. Otherwise go to RESP.
  - FIELD. Capture mem_data into field idx. If idx<n-1, drive mem_addr=ptr+idx+1 and increment idx. Otherwise go to RESP.
  - RESP. Hold resp_valid and all resp_* stable until resp_ready=1, then go to IDLE. No new grant in that same cycle.
- Arbitration is round-robin on last_grant. If both requesters are valid, the one not granted last wins. If only one is valid, it wins. last_grant resets to 1, so req0 wins the first tie.
- Address arithmetic: ptr+k is modulo 2^ADDR_WIDTH. An object at the top address wraps to 0.
- Field registers clear to 0 at each grant.
- req_ptr is sampled only on the grant cycle. Later changes are ignored.

## Timing
- Grant at cycle T. The tag is captured at T+1. Field k is captured at T+1+k. resp_valid is asserted from T+n+1.
- Latency from grant to resp_valid:
  - NIL or error: 2
  - NUMBER: 3
  - CONS: 4
  - FUNC_PRIM: 5
- Back-to-back: earliest next grant is the cycle after the resp_ready handshake.
- At most one ready pulse per cycle. ready is never asserted outside IDLE.
- Reset values (immediately on rst_n low, at any state, including mid-fetch):
  - state=IDLE, mem_addr=0, req*_ready=0
  - resp_valid=0, resp_id=0, resp_tag=0, resp_f1..f3=0, resp_err=0
  - last_grant=1
- An in-flight fetch is dropped on reset and no response is produced.
- Held requests: a requester not granted keeps req_valid high and is served next. It waits at most one other object fetch.

## Test plan
- Memory holds NUMBER,0x12 at 0x1. req0 ptr=0x1 -> req0_ready pulse at T. At T+3: resp_valid, id=0, tag=TYPE_NUMBER, f1=0x12, f2=f3=0, err=0.
- CONS at 0xF, fields 0x5,0xC. req1 ptr=0xF, resp_ready tied 1 -> resp at T+4 with tag=TYPE_CONS, f1=0x05, f2=0x0C, id=1. Then FUNC_PRIM at 0x5 -> f1=TYPE_PRIM_CONS, f2=f3=NIL, latency 5.
- req0 and req1 both held valid from reset -> grants alternate 0,1,0,1. Each response id matches its grant. Neither requester waits more than one fetch.
- Backpressure: resp_ready=0 for 10 cycles after a NIL fetch at ptr=0x0 -> resp_valid and all fields stable. No ready pulse until 1 cycle after resp_ready=1.
- Wrap: ADDR_WIDTH=8, CONS at 0xFE -> mem_addr sequence 0xFE,0xFF,0x00. Unknown tag 0x7F at 0x20 -> err=1, fields 0, latency 2.
- Assert rst_n=0 during FIELD of a CONS fetch -> all outputs 0 asynchronously and no response. After release, a tie is granted to req0.
